// File: rtl/bcd_display_scan.sv
// Four-digit multiplexed 7-segment scanner with a frame-synchronous shadow register.
// Optional leading-zero blanking is enabled by defining BCD_SCAN_LZB_EN.
module bcd_display_scan #(
  parameter int SCAN_DIV = 50000,
  parameter int GUARD    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] digits,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        frame_tick
);

  localparam int             CW      = $clog2(SCAN_DIV);
  localparam logic [CW-1:0]  CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0]  GUARD_C = CW'(GUARD);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   shadow;
  logic          slot_end;
  logic          frame_end;
  logic [3:0]    nibble;
  logic [3:0]    an_nxt;
  logic [6:0]    seg_nxt;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

`ifdef BCD_SCAN_LZB_EN
  // Blank a digit when it and every digit to its left are zero; digit 0 always shows.
  function automatic logic lz_blank(input logic [1:0] i, input logic [15:0] sh);
    logic b;
    case (i)
      2'd3:    b = (sh[15:12] == 4'd0);
      2'd2:    b = (sh[15:8]  == 8'd0);
      2'd1:    b = (sh[15:4]  == 12'd0);
      default: b = 1'b0;
    endcase
    return b;
  endfunction
`endif

  // Stage 0: decode the slot from the pre-edge cnt/idx/shadow state
  always_comb begin
    slot_end  = (cnt == CNT_MAX);
    frame_end = slot_end && (idx == 2'd3);
    case (idx)
      2'd0:    nibble = shadow[3:0];
      2'd1:    nibble = shadow[7:4];
      2'd2:    nibble = shadow[11:8];
      default: nibble = shadow[15:12];
    endcase
    an_nxt  = 4'b1111;
    seg_nxt = 7'h7F;
    if (cnt >= GUARD_C) begin
      an_nxt[idx] = 1'b0;
`ifdef BCD_SCAN_LZB_EN
      seg_nxt = lz_blank(idx, shadow) ? 7'h7F : seg_decode(nibble);
`else
      seg_nxt = seg_decode(nibble);
`endif
    end
  end

  // Stage 1: scan state, shadow load and registered display outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      idx        <= 2'd0;
      shadow     <= 16'h0000;
      an         <= 4'b1111;
      seg        <= 7'h7F;
      frame_tick <= 1'b0;
    end else begin
      cnt <= slot_end ? '0 : cnt + 1'b1;
      if (slot_end) idx <= idx + 2'd1;
      if (frame_end) shadow <= digits;
      an         <= an_nxt;
      seg        <= seg_nxt;
      frame_tick <= frame_end;
    end
  end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Scoreboard bench for bcd_display_scan: a time-indexed reference model predicts each cycle's outputs.
module tb_bcd_display_scan;

  localparam int SD = 8;
  localparam int GD = 2;
  localparam int FR = 4 * SD;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] digits = 16'h0000;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        frame_tick;

  bcd_display_scan #(.SCAN_DIV(SD), .GUARD(GD)) dut (
    .clk(clk), .reset(reset), .digits(digits),
    .an(an), .seg(seg), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         k;
    logic [3:0] an;
    logic [6:0] seg;
    logic       ft;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          k = 0;
  logic [15:0] hist [0:4095];
  logic [6:0]  seg_tbl [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Expected outputs after rising edge kk (kk counted from reset release).
  function automatic exp_t model(input int kk);
    exp_t        e;
    int          n, pos, d, last_load;
    logic [15:0] sh, hi;
    logic [3:0]  nib;
    n   = kk - 1;
    pos = n % SD;
    d   = (n / SD) % 4;
    last_load = FR * (n / FR);
    sh  = (last_load == 0) ? 16'h0000 : hist[last_load];
    e.k  = kk;
    e.ft = (kk % FR == 0);
    if (pos < GD) begin
      e.an  = 4'b1111;
      e.seg = 7'h7F;
    end else begin
      e.an  = ~(4'b0001 << d);
      nib   = 4'((sh >> (4 * d)) & 16'hF);
      e.seg = (nib <= 4'd9) ? seg_tbl[nib] : 7'h3F;
      hi    = sh >> (4 * d);
`ifdef BCD_SCAN_LZB_EN
      if (d > 0 && hi == 16'h0000) e.seg = 7'h7F;
`endif
    end
    return e;
  endfunction

  task automatic cycle(input logic [15:0] nd);
    exp_t e;
    @(posedge clk);
    k++;
    hist[k] = digits;
    e = model(k);
    sb.push_back(e);
    @(negedge clk);
    digits = nd;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check($sformatf("an@%0d", e.k), int'(an), int'(e.an));
      check($sformatf("seg@%0d", e.k), int'(seg), int'(e.seg));
      check($sformatf("frame_tick@%0d", e.k), int'(frame_tick), int'(e.ft));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with clock running
    repeat (3) begin
      @(negedge clk);
      check("rst_an", int'(an), 'hF);
      check("rst_seg", int'(seg), 'h7F);
      check("rst_ft", int'(frame_tick), 0);
    end
    reset = 1'b1;
    k = 0;

    for (int i = 0; i < 2 * FR; i++) cycle(16'h1234);
    for (int i = 0; i < FR + 12; i++) cycle(16'h1234);
    for (int i = 0; i < 2 * FR; i++) cycle(16'h5678);
    for (int i = 0; i < 2 * FR; i++) cycle(16'h00A7);
    for (int i = 0; i < 2 * FR; i++) cycle(16'h0000);
    for (int i = 0; i < 8 * FR; i++) cycle(16'($urandom));
    for (int i = 0; i < 2 * FR; i++) cycle(16'h0A00 | 16'($urandom_range(0, 15)));

    // Mid-slot reset while an anode is driven
    while ((k % SD) != 5) cycle(16'h9999);
    #1 reset = 1'b0;
    #1;
    check("midrst_an", int'(an), 'hF);
    check("midrst_seg", int'(seg), 'h7F);
    check("midrst_ft", int'(frame_tick), 0);
    repeat (2) @(negedge clk);
    check("midrst_hold_an", int'(an), 'hF);
    reset = 1'b1;
    k = 0;
    for (int i = 0; i < 3 * FR; i++) cycle(16'($urandom));

    @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
